lsram_fifo_ctrl: RTL and testbench

- Single-clock first-word-fall-through (FWFT) FIFO controller.
- Drives an external simple two-port LSRAM block: 64 deep x 64 wide, write port plus read port, read data registered inside the RAM with 1-cycle latency.
- Owns the write/read pointers, occupancy count and flags, and the prefetch logic that keeps Q valid.
- Sits between the digitizer sample packer (writer) and the readout/transfer engine (reader).

---
 rtl/lsram_fifo_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lsram_fifo_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lsram_fifo_ctrl.sv
// lsram_fifo_ctrl
// ---------------
// Single-clock first-word-fall-through FIFO controller for an external
// simple two-port LSRAM (write port + read port, registered read data with
// one cycle of latency). The controller owns the write/read pointers, the
// occupancy counters and flags, and the prefetch logic that keeps Q valid.
// Words live either in the RAM (ram_cnt_r of them) or on the RAM output
// register that feeds Q (q_valid_r).
//
// Optional feature macro: LSRAM_FIFO_CTRL_ERRFLAG_EN
//   defined   -> OVERFLOW / UNDERFLOW are registered one-cycle error pulses
//   undefined -> OVERFLOW / UNDERFLOW are tied low
//
// Ports:
//   CLK         clock for all logic and both RAM ports
//   RESET       synchronous active-high reset
//   WE, DATA    write request and write data
//   FULL, AFULL RAM holds DEPTH words / COUNT >= AF_THRESH
//   RE          read acknowledge, consumes Q while EMPTY=0
//   Q, EMPTY    head-of-FIFO word and its (inverted) valid flag
//   AEMPTY      COUNT <= AE_THRESH
//   COUNT       total words held (RAM plus Q)
//   OVERFLOW    write attempted while FULL (optional)
//   UNDERFLOW   read attempted while EMPTY (optional)
//   RAM_W_*     RAM write port (data, address, enable)
//   RAM_R_*     RAM read port (address, enable, registered data in)

module lsram_fifo_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int AF_THRESH  = 60,
  parameter int AE_THRESH  = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WE,
  input  logic [DATA_WIDTH-1:0] DATA,
  output logic                  FULL,
  output logic                  AFULL,
  input  logic                  RE,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  EMPTY,
  output logic                  AEMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  output logic [DATA_WIDTH-1:0] RAM_W_DATA,
  output logic [ADDR_WIDTH-1:0] RAM_W_ADDR,
  output logic                  RAM_W_EN,
  output logic [ADDR_WIDTH-1:0] RAM_R_ADDR,
  output logic                  RAM_R_EN,
  input  logic [DATA_WIDTH-1:0] RAM_R_DATA
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   AF_C     = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_C     = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wptr_r;
  logic [ADDR_WIDTH-1:0] rptr_r;
  logic [ADDR_WIDTH-1:0] wptr_nxt_s;
  logic [ADDR_WIDTH-1:0] rptr_nxt_s;
  logic [ADDR_WIDTH:0]   ram_cnt_r;
  logic [ADDR_WIDTH:0]   ram_cnt_nxt_s;
  logic [ADDR_WIDTH:0]   count_nxt_s;
  logic                  q_valid_r;
  logic                  q_valid_nxt_s;
  logic                  full_r;
  logic                  afull_r;
  logic                  aempty_r;
  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic                  pref_s;

  // FULL is the registered flag, so a write in the same cycle as a freeing
  // read is still dropped. Both RAM strobes are held off during reset.
  assign wr_ok_s = WE & ~full_r & ~RESET;
  assign rd_ok_s = RE & q_valid_r;
  // Refill the output register whenever it is empty or being consumed.
  assign pref_s  = (~q_valid_r | rd_ok_s) & (ram_cnt_r != CNT_ZERO) & ~RESET;

  // Next-state computation for pointers, RAM occupancy and the Q valid bit
  always_comb begin
    wptr_nxt_s    = wptr_r;
    rptr_nxt_s    = rptr_r;
    ram_cnt_nxt_s = ram_cnt_r;
    q_valid_nxt_s = q_valid_r;

    if (wr_ok_s) begin
      wptr_nxt_s = wptr_r + PTR_ONE;
    end else begin
      wptr_nxt_s = wptr_r;
    end

    if (pref_s) begin
      rptr_nxt_s    = rptr_r + PTR_ONE;
      q_valid_nxt_s = 1'b1;
    end else if (rd_ok_s) begin
      rptr_nxt_s    = rptr_r;
      q_valid_nxt_s = 1'b0;
    end else begin
      rptr_nxt_s    = rptr_r;
      q_valid_nxt_s = q_valid_r;
    end

    // A simultaneous write and prefetch leave the RAM occupancy unchanged.
    case ({wr_ok_s, pref_s})
      2'b10:   ram_cnt_nxt_s = ram_cnt_r + CNT_ONE;
      2'b01:   ram_cnt_nxt_s = ram_cnt_r - CNT_ONE;
      default: ram_cnt_nxt_s = ram_cnt_r;
    endcase

    count_nxt_s = ram_cnt_nxt_s + {{ADDR_WIDTH{1'b0}}, q_valid_nxt_s};
  end

  // State and flag registers; flags are computed from the next-state count
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr_r    <= {ADDR_WIDTH{1'b0}};
      rptr_r    <= {ADDR_WIDTH{1'b0}};
      ram_cnt_r <= CNT_ZERO;
      q_valid_r <= 1'b0;
      full_r    <= 1'b0;
      afull_r   <= 1'b0;
      aempty_r  <= 1'b1;
    end else begin
      wptr_r    <= wptr_nxt_s;
      rptr_r    <= rptr_nxt_s;
      ram_cnt_r <= ram_cnt_nxt_s;
      q_valid_r <= q_valid_nxt_s;
      full_r    <= (ram_cnt_nxt_s == DEPTH_C);
      afull_r   <= (count_nxt_s >= AF_C);
      aempty_r  <= (count_nxt_s <= AE_C);
    end
  end

`ifdef LSRAM_FIFO_CTRL_ERRFLAG_EN
  logic overflow_r;
  logic underflow_r;

  // One-cycle error pulses for a write into FULL / a read from EMPTY
  always_ff @(posedge CLK) begin
    if (RESET) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= WE & full_r;
      underflow_r <= RE & ~q_valid_r;
    end
  end

  assign OVERFLOW  = overflow_r;
  assign UNDERFLOW = underflow_r;
`else
  assign OVERFLOW  = 1'b0;
  assign UNDERFLOW = 1'b0;
`endif

  assign FULL       = full_r;
  assign AFULL      = afull_r;
  assign AEMPTY     = aempty_r;
  assign EMPTY      = ~q_valid_r;
  assign COUNT      = ram_cnt_r + {{ADDR_WIDTH{1'b0}}, q_valid_r};
  assign Q          = RAM_R_DATA;
  assign RAM_W_DATA = DATA;
  assign RAM_W_ADDR = wptr_r;
  assign RAM_W_EN   = wr_ok_s;
  assign RAM_R_ADDR = rptr_r;
  assign RAM_R_EN   = pref_s;

endmodule

// File: tb/tb_lsram_fifo_ctrl.sv
// tb_lsram_fifo_ctrl
// Self-checking bench for lsram_fifo_ctrl. A behavioural RAM sits on the
// RAM ports. The reference model tracks the FIFO as a word count plus a
// "head presented" bit; accepted writes are pushed into a scoreboard queue
// and a negedge monitor pops and compares Q whenever a word is consumed.

module tb_lsram_fifo_ctrl;

  logic        CLK;
  logic        RESET;
  logic        WE;
  logic [63:0] DATA;
  logic        FULL;
  logic        AFULL;
  logic        RE;
  logic [63:0] Q;
  logic        EMPTY;
  logic        AEMPTY;
  logic [6:0]  COUNT;
  logic        OVERFLOW;
  logic        UNDERFLOW;
  logic [63:0] RAM_W_DATA;
  logic [5:0]  RAM_W_ADDR;
  logic        RAM_W_EN;
  logic [5:0]  RAM_R_ADDR;
  logic        RAM_R_EN;
  logic [63:0] RAM_R_DATA;

  lsram_fifo_ctrl dut (
    .CLK(CLK), .RESET(RESET), .WE(WE), .DATA(DATA), .FULL(FULL), .AFULL(AFULL),
    .RE(RE), .Q(Q), .EMPTY(EMPTY), .AEMPTY(AEMPTY), .COUNT(COUNT),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
    .RAM_W_DATA(RAM_W_DATA), .RAM_W_ADDR(RAM_W_ADDR), .RAM_W_EN(RAM_W_EN),
    .RAM_R_ADDR(RAM_R_ADDR), .RAM_R_EN(RAM_R_EN), .RAM_R_DATA(RAM_R_DATA)
  );

  // behavioural two-port RAM, registered read data
  logic [63:0] mem [64];
  always @(posedge CLK) begin
    if (RAM_W_EN) mem[RAM_W_ADDR] <= RAM_W_DATA;
    if (RAM_R_EN) RAM_R_DATA <= mem[RAM_R_ADDR];
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  // reference model state
  int m_size = 0;       // total words held
  bit m_pv = 1'b0;      // head word presented on Q
  bit m_of = 1'b0;
  bit m_uf = 1'b0;
  logic [63:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference model: advance on every clock edge from the sampled inputs
  always @(posedge CLK) begin
    int ram;
    bit wr;
    bit rd;
    bit pre;
    ram = m_size - int'(m_pv);
    if (RESET) begin
      m_size = 0;
      m_pv   = 1'b0;
      m_of   = 1'b0;
      m_uf   = 1'b0;
      exp_q.delete();
    end else begin
      wr   = WE && (ram != 64);
      rd   = RE && m_pv;
      pre  = (!m_pv || rd) && (ram != 0);
      m_of = WE && (ram == 64);
      m_uf = RE && !m_pv;
      if (wr) exp_q.push_back(DATA);
      m_size = m_size + int'(wr) - int'(rd);
      if (pre) m_pv = 1'b1;
      else if (rd) m_pv = 1'b0;
    end
  end

  // monitor: flags against the model, Q against the scoreboard on consume
  always @(negedge CLK) begin
    int ram;
    logic [63:0] exp;
    if (mon_en) begin
      ram = m_size - int'(m_pv);
      chk("empty",  {63'd0, EMPTY},  {63'd0, !m_pv});
      chk("full",   {63'd0, FULL},   {63'd0, ram == 64});
      chk("count",  {57'd0, COUNT},  64'(m_size));
      chk("afull",  {63'd0, AFULL},  {63'd0, m_size >= 60});
      chk("aempty", {63'd0, AEMPTY}, {63'd0, m_size <= 4});
      chk("ram_w_en", {63'd0, RAM_W_EN}, {63'd0, WE && (ram != 64) && !RESET});
      chk("ram_r_en", {63'd0, RAM_R_EN},
          {63'd0, (!m_pv || (RE && m_pv)) && (ram != 0) && !RESET});
      chk("ram_w_data", RAM_W_DATA, DATA);
`ifdef LSRAM_FIFO_CTRL_ERRFLAG_EN
      chk("overflow",  {63'd0, OVERFLOW},  {63'd0, m_of});
      chk("underflow", {63'd0, UNDERFLOW}, {63'd0, m_uf});
`else
      chk("overflow",  {63'd0, OVERFLOW},  64'd0);
      chk("underflow", {63'd0, UNDERFLOW}, 64'd0);
`endif
      if (RE && !EMPTY && !RESET) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underrun actual=consume expected=no_word t=%0t", $time);
        end else begin
          exp = exp_q.pop_front();
          chk("q_data", Q, exp);
        end
      end
    end
  end

  task automatic step(input bit rst, input bit we, input logic [63:0] d, input bit re);
    RESET = rst;
    WE    = we;
    DATA  = d;
    RE    = re;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int pw;
    int pr;
    RESET = 1'b1; WE = 1'b0; RE = 1'b0; DATA = 64'd0;
    step(1'b1, 1'b0, 64'd0, 1'b0);
    mon_en = 1'b1;
    step(1'b1, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'd0, 1'b0);
    chk("rst_count", {57'd0, COUNT}, 64'd0);
    chk("rst_empty", {63'd0, EMPTY}, 64'd1);
    chk("rst_aempty", {63'd0, AEMPTY}, 64'd1);

    // single word: visible two edges after the write edge
    step(1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0);
    chk("lat_empty_t1", {63'd0, EMPTY}, 64'd1);
    step(1'b0, 1'b0, 64'd0, 1'b0);
    chk("lat_empty_t2", {63'd0, EMPTY}, 64'd0);
    chk("single_q", Q, 64'hDEAD_BEEF_0123_4567);
    chk("single_count", {57'd0, COUNT}, 64'd1);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    chk("single_drained", {63'd0, EMPTY}, 64'd1);
    chk("single_count0", {57'd0, COUNT}, 64'd0);

    // fill to 65, attempt a 66th, drain in order
    for (int i = 0; i < 65; i++) step(1'b0, 1'b1, 64'(i), 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0);
    chk("fill_full", {63'd0, FULL}, 64'd1);
    chk("fill_count", {57'd0, COUNT}, 64'd65);
    chk("fill_afull", {63'd0, AFULL}, 64'd1);
    step(1'b0, 1'b1, 64'd999, 1'b0);
    chk("drop_count", {57'd0, COUNT}, 64'd65);
    for (int i = 0; i < 67; i++) step(1'b0, 1'b0, 64'd0, 1'b1);
    chk("drain_empty", {63'd0, EMPTY}, 64'd1);

    // write and read together at full
    for (int i = 0; i < 65; i++) step(1'b0, 1'b1, 64'(1000 + i), 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b1, 64'd777, 1'b1);
    chk("wr_rd_full_full", {63'd0, FULL}, 64'd0);
    chk("wr_rd_full_count", {57'd0, COUNT}, 64'd64);
    for (int i = 0; i < 66; i++) step(1'b0, 1'b0, 64'd0, 1'b1);

    // streaming past the pointer wrap with constant occupancy
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 64'(5000 + i), 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 64'(5010 + i), 1'b1);
    chk("stream_count", {57'd0, COUNT}, 64'd10);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 64'd0, 1'b1);

    // reset mid-stream with 30 words held
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 64'(9000 + i), 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0);
    chk("pre_rst_count", {57'd0, COUNT}, 64'd30);
    step(1'b1, 1'b1, 64'd55, 1'b1);
    chk("mid_rst_count", {57'd0, COUNT}, 64'd0);
    chk("mid_rst_empty", {63'd0, EMPTY}, 64'd1);
    step(1'b0, 1'b1, 64'h1, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0);
    chk("post_rst_q", Q, 64'h1);
    chk("post_rst_empty", {63'd0, EMPTY}, 64'd0);

    // randomized traffic with varying write/read pressure and rare resets
    for (int seg = 0; seg < 6; seg++) begin
      pw = $urandom_range(20, 95);
      pr = $urandom_range(20, 95);
      for (int i = 0; i < 500; i++) begin
        step($urandom_range(0, 599) == 0,
             $urandom_range(0, 99) < pw,
             {$urandom, $urandom},
             $urandom_range(0, 99) < pr);
      end
    end
    step(1'b0, 1'b0, 64'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
